// File: rtl/hex_msg_scroller.sv
// Seven-segment message terminal: letters committed on KEY[0] fill a buffer; a terminator scrolls it across HEX3..HEX0.
// Latency: commit pulse 2+DEBOUNCE+1 cycles after KEY[0] falls; HEX registers update on the edge that consumes commit or tick.
// Backpressure: none; letters committed into a full buffer are dropped.
module hex_msg_scroller #(
    parameter int TICK_DIV = 25_000_000,
    parameter int DEBOUNCE = 500_000,
    parameter int MAX_LEN  = 8
) (
    input  logic       CLOCK_50,
    input  logic [0:1] KEY,
    input  logic [0:5] SW,
    output logic [0:6] HEX0,
    output logic [0:6] HEX1,
    output logic [0:6] HEX2,
    output logic [0:6] HEX3
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int PW = $clog2(MAX_LEN + 4);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic {ENTRY, SCROLL} state_t;

    function automatic logic [6:0] glyph_of(input logic [5:0] code);
        case (code)
            6'b100000: glyph_of = 7'b0001000; // A
            6'b110000: glyph_of = 7'b1100000; // B
            6'b100100: glyph_of = 7'b0110001; // C
            6'b100110: glyph_of = 7'b1000010; // D
            6'b100010: glyph_of = 7'b0110000; // E
            6'b110100: glyph_of = 7'b0111000; // F
            6'b110110: glyph_of = 7'b0100001; // G
            6'b110010: glyph_of = 7'b1001000; // H
            6'b010100: glyph_of = 7'b1111001; // I
            6'b010110: glyph_of = 7'b1000011; // J
            6'b111000: glyph_of = 7'b1110001; // L
            6'b101100: glyph_of = 7'b0101011; // M
            6'b101110: glyph_of = 7'b1101010; // N
            6'b111100: glyph_of = 7'b0011000; // P
            6'b111110: glyph_of = 7'b0001100; // Q
            6'b111010: glyph_of = 7'b1111010; // R
            6'b011100: glyph_of = 7'b0100100; // S
            6'b011110: glyph_of = 7'b1110000; // T
            6'b101001: glyph_of = 7'b1000001; // U
            6'b111001: glyph_of = 7'b1100011; // V
            6'b011111: glyph_of = 7'b1010101; // W
            6'b101101: glyph_of = 7'b1001001; // X
            6'b101111: glyph_of = 7'b1000100; // Y
            6'b101011: glyph_of = 7'b0010010; // Z
            default:   glyph_of = BLANK;
        endcase
    endfunction

    // Slots at or beyond the stored count read as the terminator, which renders blank.
    function automatic logic [5:0] code_at(input logic [MAX_LEN-1:0][5:0] m, input int idx, input int n);
        code_at = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i == idx && i < n) code_at = m[i];
        end
    endfunction

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge CLOCK_50 or negedge KEY[1]) begin
        if (!KEY[1]) rst_sync_q <= '0;
        else         rst_sync_q <= rst_sync_d;
    end

    logic [1:0]    key_sync_q, key_sync_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          db_lvl_q, db_lvl_d;
    logic          armed_q, armed_d;
    logic          commit_q, commit_d;
    logic          key_s;

    assign key_sync_d = {key_sync_q[0], KEY[0]};
    assign key_s      = key_sync_q[1];

    // Until the key has been seen released for DEBOUNCE cycles, a held key cannot produce a commit.
    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        armed_d  = armed_q;
        if (!armed_q) begin
            if (key_s) begin
                if (db_cnt_q == DW'(DEBOUNCE - 1)) armed_d = 1'b1;
                else                               db_cnt_d = db_cnt_q + DW'(1);
            end
        end else if (key_s != db_lvl_q) begin
            if (db_cnt_q == DW'(DEBOUNCE - 1)) db_lvl_d = key_s;
            else                               db_cnt_d = db_cnt_q + DW'(1);
        end
        commit_d = db_lvl_q & ~db_lvl_d;
    end

    state_t                    state_q, state_d;
    logic [CW-1:0]             count_q, count_d;
    logic [PW-1:0]             pos_q, pos_d, last_pos;
    logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
    logic [MAX_LEN-1:0][5:0]   msg_q, msg_d;
    logic [3:0][6:0]           hex_q, hex_d;
    logic [5:0]                sw_code;
    logic                      sw_valid;
    logic                      tick;

    assign sw_code  = SW;
    assign sw_valid = (glyph_of(sw_code) != BLANK);
    assign tick     = (state_q == SCROLL) && (tick_cnt_q == TW'(TICK_DIV - 1));
    assign last_pos = PW'(count_q) + PW'(3);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state_q <= ENTRY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pos_d      = pos_q;
        tick_cnt_d = tick_cnt_q;
        msg_d      = msg_q;
        case (state_q)
            ENTRY: begin
                tick_cnt_d = '0;
                if (commit_q) begin
                    if (sw_valid) begin
                        if (count_q < CW'(MAX_LEN)) begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                if (count_q == CW'(i)) msg_d[i] = sw_code;
                            end
                            count_d = count_q + CW'(1);
                        end
                    end else if (count_q != '0) begin
                        state_d = SCROLL;
                        pos_d   = '0;
                    end
                end
            end
            SCROLL: begin
                if (commit_q) begin
                    state_d    = ENTRY;
                    count_d    = '0;
                    pos_d      = '0;
                    tick_cnt_d = '0;
                end else if (tick) begin
                    tick_cnt_d = '0;
                    pos_d      = (pos_q == last_pos) ? '0 : pos_q + PW'(1);
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
        endcase
    end

    // Display is rendered from next-state values so HEX lands on the same edge as the state it shows.
    always_comb begin : hex_view
        int n;
        int len;
        int idx;
        n   = int'(count_d);
        len = n + 4;
        idx = 0;
        for (int k = 0; k < 4; k++) hex_d[k] = BLANK;
        if (state_d == ENTRY) begin
            for (int k = 0; k < 4; k++) hex_d[k] = glyph_of(code_at(msg_d, n - 1 - k, n));
        end else begin
            for (int j = 0; j < 4; j++) begin
                idx = int'(pos_d) + j;
                if (idx >= len) idx = idx - len;
                hex_d[3-j] = glyph_of(code_at(msg_d, idx, n));
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_sync_q <= 2'b11;
            db_cnt_q   <= '0;
            db_lvl_q   <= 1'b1;
            armed_q    <= 1'b0;
            commit_q   <= 1'b0;
            count_q    <= '0;
            pos_q      <= '0;
            tick_cnt_q <= '0;
            msg_q      <= '0;
            hex_q      <= {4{BLANK}};
        end else begin
            key_sync_q <= key_sync_d;
            db_cnt_q   <= db_cnt_d;
            db_lvl_q   <= db_lvl_d;
            armed_q    <= armed_d;
            commit_q   <= commit_d;
            count_q    <= count_d;
            pos_q      <= pos_d;
            tick_cnt_q <= tick_cnt_d;
            msg_q      <= msg_d;
            hex_q      <= hex_d;
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];

endmodule

// File: doc/hex_msg_scroller.md
# hex_msg_scroller

- Sequences the four-digit seven-segment display as a message terminal.
- Input: letters entered one at a time on SW and committed with KEY[0], stored in a small buffer.
- Output: on a terminator code, the stored message scrolls right-to-left across HEX3..HEX0 and wraps indefinitely.
- It sits between the board switches/keys and the HEX outputs, replacing direct per-letter decode.

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per scroll step (0.5 s at 50 MHz).
- `DEBOUNCE`, default 500_000: cycles KEY[0] must be stable before a level change is accepted.
- `MAX_LEN`, default 8: message buffer depth in letters.
- `CLOCK_50` input, 1 bit: the single clock, rising edge.
- `KEY` input, [0:1]:
  - KEY[1] is the reset; one clock; reset is asynchronous and active-low.
  - KEY[0] is the commit pushbutton, active-low, asynchronous to `CLOCK_50`.
- `SW` input, [0:5]: letter code; bit string below is written SW[0]..SW[5].
- `HEX0`, `HEX1`, `HEX2`, `HEX3` output reg, [0:6] each: active-low segments a..g. HEX0 is the rightmost digit.

## Operation
- Letter codes (24 valid codes; every other code, including 000000, is the terminator):
  - A 100000, B 110000, C 100100, D 100110, E 100010, F 110100
  - G 110110, H 110010, I 010100, J 010110, L 111000, M 101100
  - N 101110, P 111100, Q 111110, R 111010, S 011100, T 011110
  - U 101001, V 111001, W 011111, X 101101, Y 101111, Z 101011
- Glyphs come from the team letter-glyph table. A = 0001000; blank = 1111111.
- Buffer stores the 6-bit codes, not glyphs.
- KEY[0] input path: 2-FF synchronizer, then debounce counter, then falling-edge detect. This produces a 1-cycle `commit` pulse per press. Release produces nothing.
- States:
  - ENTRY:
    - Display is right-justified: HEX0 = newest letter, HEX1 = previous, and so on. Positions without a letter are blank.
    - On `commit` with a valid code and count < MAX_LEN: write the code to buf[count]; count++.
    - On `commit` with a valid code and count == MAX_LEN: dropped; no state change.
    - On `commit` with a terminator and count > 0: go to SCROLL; pos = 0; tick counter = 0.
    - On `commit` with a terminator and count == 0: ignored.
  - SCROLL:
    - Virtual sequence V = buf[0..count-1] followed by 4 blanks; L = count + 4.
    - HEX3 = V[pos], HEX2 = V[(pos+1) mod L], HEX1 = V[(pos+2) mod L], HEX0 = V[(pos+3) mod L].
    - On each tick: pos = (pos+1) mod L.
    - On `commit` with any code: count = 0; pos = 0; go to ENTRY (display all blank). Takes priority over a same-cycle tick.
- Widths:
  - count is clog2(MAX_LEN+1) bits.
  - pos wraps at L, not at a power of two.
  - Tick counter counts 0..TICK_DIV-1 and runs only in SCROLL.
- SW is sampled in the `commit` cycle only; SW changes at any other time have no effect.

## Timing
- Reset (KEY[1] low, asynchronous):
  - state = ENTRY; count = 0; pos = 0; tick counter = 0; debounce counter = 0.
  - Synchronizer and debounced level = 1.
  - All HEX = 1111111.
- Reset is released synchronously through the design's reset logic.
- Reset mid-press: the key is seen as released after reset. A still-held key generates no commit until it is released and pressed again.
- Press latency: KEY[0] falls; 2 sync cycles; DEBOUNCE stable cycles; `commit` asserts on the next cycle.
- HEX registers reflect the new buffer/state one cycle after `commit`.
- Glitches shorter than DEBOUNCE cycles produce no commit.
- Tick is asserted in the cycle the counter equals TICK_DIV-1. The counter returns to 0 and pos advances in that same cycle. HEX updates the following cycle.
- The first tick arrives TICK_DIV cycles after entering SCROLL.
- All outputs are registered; no combinational path from SW or KEY to HEX.

## Test plan
Bench uses TICK_DIV=8, DEBOUNCE=4, MAX_LEN=8.
- Reset: hold KEY[1]=0 with KEY[0]=0 and random SW -> HEX0..3 = 1111111, no commit.
  - Release reset while KEY[0] is still low -> still no commit until KEY[0] goes high and then low again.
- Entry: commit A, B, C -> HEX3 blank, HEX2=A, HEX1=B, HEX0=C.
  - A 2-cycle KEY[0] glitch -> no change.
  - SW toggled without a press -> no change.
- Overflow: commit 9 valid letters -> count stays 8; the 9th letter is absent from the scroll sequence.
- Scroll wrap: commit A then terminator 000000.
  - L = 5; display starts A,_,_,_ on HEX3..HEX0.
  - Each 8 cycles: _,_,_,_ ; then _,_,_,A ; then _,_,A,_ ; then _,A,_,_ ; then back to A,_,_,_.
- Empty terminator: terminator with count 0 -> stays in ENTRY, all blank.
- Exit scroll: commit during SCROLL in the same cycle as a tick -> ENTRY, all blank, pos not advanced.
  - Next commit of B -> HEX0=B.
